// File: rtl/config_chain_loader.sv
// Serializes configuration bytes MSB-first onto a shift chain. Each byte takes 1 fetch cycle and 8 shift cycles.
// in_ready is high only in FETCH, so the source is held off while a byte shifts out. A starved FETCH aborts with a sticky err.
module config_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       chain_data,
    output logic       chain_en,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [15:0] LAST_BIT  = 16'(CHAIN_LEN - 1);
    localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  sreg, sreg_nxt;
    logic [2:0]  bitpos, bitpos_nxt;
    logic [15:0] count, count_nxt;
    logic [15:0] wait_cnt, wait_cnt_nxt;
    logic        err_q, err_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            sreg     <= 8'd0;
            bitpos   <= 3'd0;
            count    <= 16'd0;
            wait_cnt <= 16'd0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            sreg     <= sreg_nxt;
            bitpos   <= bitpos_nxt;
            count    <= count_nxt;
            wait_cnt <= wait_cnt_nxt;
            err_q    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        sreg_nxt     = sreg;
        bitpos_nxt   = bitpos;
        count_nxt    = count;
        wait_cnt_nxt = wait_cnt;
        err_nxt      = err_q;
        in_ready     = 1'b0;
        chain_data   = 1'b0;
        chain_en     = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;

        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    count_nxt    = 16'd0;
                    wait_cnt_nxt = 16'd0;
                    err_nxt      = 1'b0;
                    state_nxt    = S_FETCH;
                end
            end
            S_FETCH: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sreg_nxt     = in_data;
                    bitpos_nxt   = 3'd7;
                    wait_cnt_nxt = 16'd0;
                    state_nxt    = S_SHIFT;
                end else begin
                    wait_cnt_nxt = wait_cnt + 16'd1;
                    if (wait_cnt == LAST_WAIT) begin
                        err_nxt   = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_SHIFT: begin
                chain_en   = 1'b1;
                chain_data = sreg[7];
                sreg_nxt   = {sreg[6:0], 1'b0};
                count_nxt  = count + 16'd1;
                bitpos_nxt = bitpos - 3'd1;
                // The chain-length check wins so a partial final byte ends the load early.
                if (count == LAST_BIT) begin
                    state_nxt = S_DONE;
                end else if (bitpos == 3'd0) begin
                    state_nxt = S_FETCH;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign err = err_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Scoreboarded bench: three loader instances (16-bit, 12-bit, short-timeout); a negedge monitor checks every shifted bit.
module tb_config_chain_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       st  [3];
    logic       dv  [3];
    logic [7:0] dd  [3];
    logic       rdy [3];
    logic       cd  [3];
    logic       ce  [3];
    logic       bsy [3];
    logic       dn  [3];
    logic       er  [3];

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          expq    [3][$];
    int          shifts  [3] = '{0, 0, 0};
    logic [15:0] chain_m [3];

    config_chain_loader #(.CHAIN_LEN(16), .TIMEOUT(255)) u16 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .in_data(dd[0]), .in_valid(dv[0]),
        .in_ready(rdy[0]), .chain_data(cd[0]), .chain_en(ce[0]), .busy(bsy[0]),
        .done(dn[0]), .err(er[0]));

    config_chain_loader #(.CHAIN_LEN(12), .TIMEOUT(255)) u12 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .in_data(dd[1]), .in_valid(dv[1]),
        .in_ready(rdy[1]), .chain_data(cd[1]), .chain_en(ce[1]), .busy(bsy[1]),
        .done(dn[1]), .err(er[1]));

    config_chain_loader #(.CHAIN_LEN(16), .TIMEOUT(4)) uto (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .in_data(dd[2]), .in_valid(dv[2]),
        .in_ready(rdy[2]), .chain_data(cd[2]), .chain_en(ce[2]), .busy(bsy[2]),
        .done(dn[2]), .err(er[2]));

    // Behavioural chain: captures chain_data on the edge ending an enabled cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++)
            if (ce[i] === 1'b1) chain_m[i] <= {chain_m[i][14:0], cd[i]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ce[i] === 1'b1) begin
                shifts[i]++;
                if (expq[i].size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_shift dut%0d: chain_en high with no expected bit at %0t", i, $time);
                end else begin
                    chk($sformatf("chain_bit dut%0d", i), 32'(cd[i]), 32'(expq[i].pop_front()));
                end
            end
        end
    end

    task automatic run_load(input int d, input logic [23:0] bytes, input int noffer,
                            input int nbits, input int nacc_exp, input int stall,
                            input int restart_c, input int done_exp, input string tag);
        int c, idx, done_c, stall_cnt, sh0;
        logic [15:0] mask;
        for (int k = 0; k < nbits; k++) expq[d].push_back(bytes[23-k]);
        sh0 = shifts[d];
        @(negedge clk);
        st[d] = 1'b1;
        dv[d] = 1'b0;
        @(posedge clk);
        c = 0; idx = 0; done_c = -1; stall_cnt = 0;
        while (done_c < 0 && c < 300) begin
            @(negedge clk);
            c++;
            st[d] = (c == restart_c);
            if (c == 1) chk({tag, "_start_rdy_busy"}, 32'({rdy[d], bsy[d]}), 32'd3);
            if (dn[d]) begin
                done_c = c;
                chk({tag, "_rdy_at_done"}, 32'(rdy[d]), 32'd0);
            end
            if (stall_cnt > 0) begin
                dv[d] = 1'b0;
                if (rdy[d]) begin
                    chk({tag, "_stall_en_err"}, 32'({ce[d], er[d]}), 32'd0);
                    stall_cnt--;
                end
            end else if (idx < noffer) begin
                dv[d] = 1'b1;
                dd[d] = bytes[23-8*idx -: 8];
                if (rdy[d]) begin
                    idx++;
                    if (idx < noffer) stall_cnt = stall;
                end
            end else begin
                dv[d] = 1'b0;
            end
        end
        dv[d] = 1'b0;
        st[d] = 1'b0;
        chk({tag, "_done_cycle"}, 32'(done_c), 32'(done_exp));
        chk({tag, "_bytes_accepted"}, 32'(idx), 32'(nacc_exp));
        @(negedge clk);
        chk({tag, "_idle_after_done"}, 32'({bsy[d], dn[d], er[d]}), 32'd0);
        chk({tag, "_shift_cycles"}, 32'(shifts[d] - sh0), 32'(nbits));
        mask = 16'hFFFF >> (16 - nbits);
        chk({tag, "_chain"}, 32'(chain_m[d] & mask), 32'((bytes[23 -: 16] >> (16 - nbits)) & mask));
        chk({tag, "_queue_drained"}, 32'(expq[d].size()), 32'd0);
    endtask

    initial begin
        int seen_done;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            st[i] = 1'b0; dv[i] = 1'b0; dd[i] = 8'd0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk($sformatf("reset_outputs dut%0d", i),
                32'({rdy[i], cd[i], ce[i], bsy[i], dn[i], er[i]}), 32'd0);
        rst_n = 1'b1;

        run_load(0, 24'hA53C00, 2, 16, 2, 0, -1, 19, "full");
        run_load(1, 24'hFFB7C3, 3, 12, 2, 0, -1, 15, "partial");
        run_load(0, 24'hC35A00, 2, 16, 2, 5, -1, 24, "stall");
        run_load(0, 24'h5AF000, 2, 16, 2, 0, 4, 19, "restart");

        // Reset in the middle of shifting the first byte.
        for (int k = 0; k < 8; k++) expq[0].push_back(k[0] ? 1'b0 : 1'b1);
        @(negedge clk); st[0] = 1'b1;
        @(posedge clk);
        @(negedge clk); st[0] = 1'b0; dv[0] = 1'b1; dd[0] = 8'hA5;
        @(negedge clk); dv[0] = 1'b0;
        @(negedge clk); chk("midload_shifting", 32'(ce[0]), 32'd1);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midload_reset_outputs", 32'({rdy[0], cd[0], ce[0], bsy[0], dn[0], er[0]}), 32'd0);
        rst_n = 1'b1;
        expq[0].delete();
        run_load(0, 24'hA53C00, 2, 16, 2, 0, -1, 19, "after_reset");

        // Starved FETCH with TIMEOUT=4.
        @(negedge clk); st[2] = 1'b1; dv[2] = 1'b0;
        @(posedge clk);
        seen_done = 0;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            st[2] = 1'b0;
            if (dn[2]) seen_done = 1;
            if (c == 4) chk("timeout_c4_busy_err", 32'({bsy[2], er[2]}), 32'd2);
            if (c == 5) chk("timeout_c5_busy_err", 32'({bsy[2], er[2]}), 32'd1);
        end
        chk("timeout_no_done", 32'(seen_done), 32'd0);
        chk("timeout_err_sticky", 32'(er[2]), 32'd1);
        @(negedge clk); st[2] = 1'b1;
        @(posedge clk);
        @(negedge clk); st[2] = 1'b0;
        chk("restart_clears_err", 32'({er[2], bsy[2], rdy[2]}), 32'd3);
        repeat (8) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
